hazard_forward_scoreboard: RTL and testbench
============================================

Name: hazard_forward_scoreboard

Overview:
Parametrised ID-stage hazard and bypass unit. Generalises the fixed 2-port, 2-stage GPR/HI-LO forwarder to N read ports and S forwarding stages. Adds a registered scoreboard that tracks outstanding long-latency writes (divider, cache-miss loads) and stalls consumers until those writes complete. Sits between the ID stage, the EX/AM/WB result buses and the long-latency unit completion buses.

Parameters:
NUM_RD, 2, number of ID GPR read ports
NUM_STG, 2, number of forwarding stages; index 0 is the youngest (EX), higher indices are older
DATA_W, 32, data width
MAX_PEND, 4, maximum outstanding long-latency writes; range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_use  in  NUM_RD  per-port "source register used"
id_addr  in  5*NUM_RD  per-port source register; port p is bits [5p+4:5p]
rf_data  in  DATA_W*NUM_RD  register-file read data, per port
rd_addr  out  5*NUM_RD  register-file read address, equal to id_addr
rd_latest  out  DATA_W*NUM_RD  forwarded value, per port
id_use_hi / id_use_lo  in  1 each  ID reads HI / LO
hilo_latest  out  DATA_W  forwarded HI or LO value
stg_wen  in  NUM_STG  stage writes a GPR
stg_clean  in  NUM_STG  stage write data is final
stg_waddr  in  5*NUM_STG  stage GPR write address
stg_wdata  in  DATA_W*NUM_STG  stage GPR write data
stg_hi_we / stg_lo_we  in  NUM_STG each  stage writes HI / LO
stg_hi / stg_lo  in  DATA_W*NUM_STG  stage HI / LO data
wb_hi / wb_lo  in  DATA_W each  architectural HI / LO
iss_valid  in  1  long-latency op issued this cycle
iss_gpr  in  1  target is a GPR; when 0 the target is HI/LO
iss_addr  in  5  GPR target
iss_ready  out  1  issue permitted
cmp_valid  in  1  long-latency op completed this cycle
cmp_gpr  in  1  completed target is a GPR; when 0 it is HI/LO
cmp_addr  in  5  completed GPR target
flush  in  1  kill all in-flight long-latency ops
pend_cnt  out  4  outstanding op count
id_unlock  out  1  1 = ID may advance

Behaviour:
Forwarding (combinational):
- For port p, scan stages 0..NUM_STG-1. Stage s hits when stg_wen[s] is set and its waddr equals id_addr[p].
- The first hit wins. On a hit, rd_latest = stg_wdata[s]. With no hit, rd_latest = rf_data[p].
- id_addr = 0: rd_latest = 0 unconditionally; the port never stalls.
- Port p stalls when id_use[p] is set, the address is nonzero, and either:
  - the winning hit has stg_clean = 0, or
  - busy[id_addr[p]] = 1.
- hilo_latest:
  - use_hi=1, use_lo=0: first stage with hi_we set supplies the value, else wb_hi.
  - use_hi=0, use_lo=1: same scheme with lo_we and wb_lo.
  - Any other combination: 0.
- HI/LO stall when (use_hi | use_lo) and hilo_busy = 1.
- id_unlock = NOR of all port stalls and the HI/LO stall.

Scoreboard (registered):
- State: busy[31:1], hilo_busy, cnt (4 bits).
- Reset: all busy bits 0, hilo_busy 0, cnt 0. Consequently id_unlock = 1 and iss_ready = 1 in the cycle after reset.
- iss_ready = 0 when any of:
  - cnt == MAX_PEND;
  - the target is already busy (WAW stall);
  - iss_gpr = 1 and iss_addr = 0.
- Issue is accepted when iss_valid and iss_ready. It sets the target's busy bit and increments cnt.
- A completion clears the target's busy bit and decrements cnt. A completion whose target is not busy is ignored, with no cnt change.
- Issue and completion in the same cycle:
  - Same target: the clear applies first, then the set. The target stays busy and cnt is unchanged.
  - Different targets: both apply and cnt is unchanged.
- cnt saturates: never wraps below 0 or above MAX_PEND.
- flush: next cycle all busy bits = 0 and cnt = 0. Any iss_valid or cmp_valid in the flush cycle is ignored.
- rst takes priority over flush. rst mid-operation discards all pending state.
- Latency: a busy bit set at edge k stalls ID from cycle k+1. A completion at edge k releases the stall in cycle k+1, and forwarding of that result comes via the stg_* bus.
- pend_cnt = cnt.

Test Plan:
- Clean forward: stg_wen=2'b11, both stages waddr=5, stg_wdata={0xBBBB,0xAAAA}, clean=11, id_addr[0]=5 -> rd_latest[0]=0xAAAA (youngest stage wins), id_unlock=1.
- Dirty stall: stage0 waddr=7 with clean=0, id_use[1]=1, id_addr[1]=7 -> id_unlock=0. Same stimulus with id_addr[1]=0 -> id_unlock=1 and rd_latest[1]=0.
- Scoreboard: issue GPR 9; next cycle ID reads r9 -> id_unlock=0, pend_cnt=1. Complete r9 -> id_unlock=1 in the following cycle, pend_cnt=0.
- Capacity (MAX_PEND=4): issue r1..r4 -> pend_cnt=4 and iss_ready=0. Then a same-cycle issue of r5 with completion of r1 -> iss_ready still 0 that cycle; the issue is not accepted and pend_cnt=3.
- HI/LO: issue HI/LO; id_use_lo=1 -> stall. Complete HI/LO with stg_lo_we[1]=1 and stg_lo=0x1234 -> hilo_latest=0x1234, no stall.
- Flush/reset: with 3 ops pending, assert flush -> pend_cnt=0 and all stalls clear the next cycle. Asserting rst with flush gives the same result. A stray cmp_valid afterwards -> pend_cnt stays 0.

Source files
------------

// File: rtl/hazard_forward_scoreboard_if.sv
// ID-stage hazard/bypass bundle: read ports, stage result buses, HI/LO,
// and the long-latency issue/complete handshakes.
interface hazard_forward_scoreboard_if #(
    parameter int NUM_RD  = 2,
    parameter int NUM_STG = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_RD-1:0]              id_use;
    logic [NUM_RD-1:0][4:0]         id_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rf_data;
    logic [NUM_RD-1:0][4:0]         rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_latest;

    logic                           id_use_hi;
    logic                           id_use_lo;
    logic [DATA_W-1:0]              hilo_latest;

    logic [NUM_STG-1:0]             stg_wen;
    logic [NUM_STG-1:0]             stg_clean;
    logic [NUM_STG-1:0][4:0]        stg_waddr;
    logic [NUM_STG-1:0][DATA_W-1:0] stg_wdata;
    logic [NUM_STG-1:0]             stg_hi_we;
    logic [NUM_STG-1:0]             stg_lo_we;
    logic [NUM_STG-1:0][DATA_W-1:0] stg_hi;
    logic [NUM_STG-1:0][DATA_W-1:0] stg_lo;
    logic [DATA_W-1:0]              wb_hi;
    logic [DATA_W-1:0]              wb_lo;

    logic                           iss_valid;
    logic                           iss_gpr;
    logic [4:0]                     iss_addr;
    logic                           iss_ready;
    logic                           cmp_valid;
    logic                           cmp_gpr;
    logic [4:0]                     cmp_addr;
    logic                           flush;
    logic [3:0]                     pend_cnt;
    logic                           id_unlock;

    modport master (
        output id_use, id_addr, rf_data, id_use_hi, id_use_lo,
               stg_wen, stg_clean, stg_waddr, stg_wdata,
               stg_hi_we, stg_lo_we, stg_hi, stg_lo, wb_hi, wb_lo,
               iss_valid, iss_gpr, iss_addr, cmp_valid, cmp_gpr, cmp_addr, flush,
        input  rd_addr, rd_latest, hilo_latest, iss_ready, pend_cnt, id_unlock
    );

    modport slave (
        input  id_use, id_addr, rf_data, id_use_hi, id_use_lo,
               stg_wen, stg_clean, stg_waddr, stg_wdata,
               stg_hi_we, stg_lo_we, stg_hi, stg_lo, wb_hi, wb_lo,
               iss_valid, iss_gpr, iss_addr, cmp_valid, cmp_gpr, cmp_addr, flush,
        output rd_addr, rd_latest, hilo_latest, iss_ready, pend_cnt, id_unlock
    );
endinterface

// File: rtl/hazard_forward_scoreboard.sv
// ID-stage bypass network for N read ports over S result stages, plus a
// scoreboard that holds off consumers of outstanding long-latency writes.

// One read port: youngest-stage-wins bypass and per-port stall decision.
module hazard_fwd_port #(
    parameter int NUM_STG = 2,
    parameter int DATA_W  = 32
) (
    input  logic                           use_src,
    input  logic [4:0]                     addr,
    input  logic [DATA_W-1:0]              rf_data,
    input  logic [NUM_STG-1:0]             stg_wen,
    input  logic [NUM_STG-1:0]             stg_clean,
    input  logic [NUM_STG-1:0][4:0]        stg_waddr,
    input  logic [NUM_STG-1:0][DATA_W-1:0] stg_wdata,
    input  logic [31:0]                    busy,
    output logic [DATA_W-1:0]              latest,
    output logic                           stall
);
    logic hit;
    logic hit_clean;

    always_comb begin
        hit       = 1'b0;
        hit_clean = 1'b1;
        latest    = rf_data;
        // Walk oldest to youngest so the youngest hit overrides.
        for (int s = NUM_STG - 1; s >= 0; s--) begin
            if (stg_wen[s] && stg_waddr[s] == addr) begin
                hit       = 1'b1;
                hit_clean = stg_clean[s];
                latest    = stg_wdata[s];
            end
        end
        if (addr == 5'd0) latest = '0;
        stall = use_src && (addr != 5'd0) && ((hit && !hit_clean) || busy[addr]);
    end
endmodule

module hazard_forward_scoreboard #(
    parameter int NUM_RD   = 2,
    parameter int NUM_STG  = 2,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    hazard_forward_scoreboard_if.slave   bus
);
    localparam logic [3:0] MAX_C = 4'(MAX_PEND);

    typedef struct packed {
        logic       valid;
        logic       gpr;
        logic [4:0] addr;
    } ll_req_t;

    ll_req_t iss, cmp;
    assign iss = '{valid: bus.iss_valid, gpr: bus.iss_gpr, addr: bus.iss_addr};
    assign cmp = '{valid: bus.cmp_valid, gpr: bus.cmp_gpr, addr: bus.cmp_addr};

    // Scoreboard state; bit 0 of busy is tied low since r0 is never a target.
    logic [31:0] busy_q, busy_d;
    logic        hilo_q, hilo_d;
    logic [3:0]  cnt_q, cnt_d;

    // ---------------- GPR forwarding ----------------
    logic [NUM_RD-1:0] port_stall;

    assign bus.rd_addr = bus.id_addr;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        hazard_fwd_port #(.NUM_STG(NUM_STG), .DATA_W(DATA_W)) u_port (
            .use_src   (bus.id_use[p]),
            .addr      (bus.id_addr[p]),
            .rf_data   (bus.rf_data[p]),
            .stg_wen   (bus.stg_wen),
            .stg_clean (bus.stg_clean),
            .stg_waddr (bus.stg_waddr),
            .stg_wdata (bus.stg_wdata),
            .busy      (busy_q),
            .latest    (bus.rd_latest[p]),
            .stall     (port_stall[p])
        );
    end

    // ---------------- HI/LO forwarding ----------------
    logic hilo_stall;

    always_comb begin
        bus.hilo_latest = '0;
        if (bus.id_use_hi && !bus.id_use_lo) begin
            bus.hilo_latest = bus.wb_hi;
            for (int s = NUM_STG - 1; s >= 0; s--)
                if (bus.stg_hi_we[s]) bus.hilo_latest = bus.stg_hi[s];
        end else if (bus.id_use_lo && !bus.id_use_hi) begin
            bus.hilo_latest = bus.wb_lo;
            for (int s = NUM_STG - 1; s >= 0; s--)
                if (bus.stg_lo_we[s]) bus.hilo_latest = bus.stg_lo[s];
        end
    end

    assign hilo_stall    = (bus.id_use_hi || bus.id_use_lo) && hilo_q;
    assign bus.id_unlock = ~(|port_stall || hilo_stall);

    // ---------------- scoreboard ----------------
    logic cmp_hit, iss_tgt_busy, same_tgt, iss_acc;

    assign cmp_hit      = cmp.valid && (cmp.gpr ? busy_q[cmp.addr] : hilo_q);
    assign iss_tgt_busy = iss.gpr ? busy_q[iss.addr] : hilo_q;
    // A completion retiring the very target being issued lets the reissue
    // through: clear-then-set leaves it busy with the count unchanged.
    assign same_tgt     = cmp_hit && (cmp.gpr == iss.gpr) &&
                          (!iss.gpr || cmp.addr == iss.addr);

    assign bus.iss_ready = (cnt_q != MAX_C) &&
                           !(iss_tgt_busy && !same_tgt) &&
                           !(iss.gpr && iss.addr == 5'd0);
    assign iss_acc       = iss.valid && bus.iss_ready;
    assign bus.pend_cnt  = cnt_q;

    always_comb begin
        busy_d = busy_q;
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
        if (cmp_hit) begin
            if (cmp.gpr) busy_d[cmp.addr] = 1'b0;
            else         hilo_d = 1'b0;
        end
        if (iss_acc) begin
            if (iss.gpr) busy_d[iss.addr] = 1'b1;
            else         hilo_d = 1'b1;
        end
        case ({iss_acc, cmp_hit})
            2'b10:   if (cnt_q < MAX_C)  cnt_d = cnt_q + 4'd1;
            2'b01:   if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            busy_q <= '0;
            hilo_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed bench for hazard_forward_scoreboard: bypass priority, dirty and
// scoreboard stalls, capacity, HI/LO, flush and reset.
module tb_hazard_forward_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_forward_scoreboard_if #(.NUM_RD(2), .NUM_STG(2), .DATA_W(32)) bus ();

    hazard_forward_scoreboard #(
        .NUM_RD(2), .NUM_STG(2), .DATA_W(32), .MAX_PEND(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_gpr(input logic [4:0] a);
        bus.iss_valid = 1'b1; bus.iss_gpr = 1'b1; bus.iss_addr = a;
        tick();
        bus.iss_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.id_use = '0;   bus.id_addr = '0;   bus.rf_data = '0;
        bus.id_use_hi = 0; bus.id_use_lo = 0;
        bus.stg_wen = '0;  bus.stg_clean = '0; bus.stg_waddr = '0; bus.stg_wdata = '0;
        bus.stg_hi_we = '0; bus.stg_lo_we = '0; bus.stg_hi = '0;   bus.stg_lo = '0;
        bus.wb_hi = 32'h4848_4848; bus.wb_lo = 32'h4c4c_4c4c;
        bus.iss_valid = 0; bus.iss_gpr = 0; bus.iss_addr = '0;
        bus.cmp_valid = 0; bus.cmp_gpr = 0; bus.cmp_addr = '0;
        bus.flush = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_pend",   32'(bus.pend_cnt), 0);
        check("rst_unlock", 32'(bus.id_unlock), 1);
        check("rst_ready",  32'(bus.iss_ready), 1);

        // Clean forward, youngest stage wins
        bus.stg_wen = 2'b11; bus.stg_clean = 2'b11;
        bus.stg_waddr[0] = 5; bus.stg_waddr[1] = 5;
        bus.stg_wdata[0] = 32'hAAAA; bus.stg_wdata[1] = 32'hBBBB;
        bus.id_use = 2'b01; bus.id_addr[0] = 5; bus.rf_data[0] = 32'h5555;
        #1;
        check("fwd_young",  bus.rd_latest[0], 32'hAAAA);
        check("fwd_unlock", 32'(bus.id_unlock), 1);
        check("rd_addr",    32'(bus.rd_addr[0]), 5);
        bus.stg_wen = 2'b10; #1;
        check("fwd_old",    bus.rd_latest[0], 32'hBBBB);
        bus.id_addr[0] = 6; #1;
        check("fwd_rf",     bus.rd_latest[0], 32'h5555);

        // Dirty stall on port 1
        bus.stg_wen = 2'b01; bus.stg_clean = 2'b00; bus.stg_waddr[0] = 7;
        bus.stg_wdata[0] = 32'h7777; bus.rf_data[1] = 32'h1111;
        bus.id_use = 2'b10; bus.id_addr[1] = 7; #1;
        check("dirty_stall", 32'(bus.id_unlock), 0);
        bus.id_use = 2'b00; #1;
        check("dirty_unused", 32'(bus.id_unlock), 1);
        bus.id_use = 2'b10; bus.id_addr[1] = 0; #1;
        check("r0_unlock",  32'(bus.id_unlock), 1);
        check("r0_zero",    bus.rd_latest[1], 0);
        bus.stg_wen = 2'b00; bus.id_use = 2'b00;

        // Scoreboard GPR issue / complete
        bus.iss_gpr = 1; bus.iss_addr = 9; #1;
        check("iss_ready9", 32'(bus.iss_ready), 1);
        issue_gpr(9);
        bus.id_use = 2'b01; bus.id_addr[0] = 9; #1;
        check("sb_stall",   32'(bus.id_unlock), 0);
        check("sb_pend1",   32'(bus.pend_cnt), 1);
        bus.iss_gpr = 1; bus.iss_addr = 9; #1;
        check("waw_ready",  32'(bus.iss_ready), 0);
        bus.iss_addr = 0; #1;
        check("r0_ready",   32'(bus.iss_ready), 0);
        bus.cmp_valid = 1; bus.cmp_gpr = 1; bus.cmp_addr = 9;
        tick();
        bus.cmp_valid = 0;
        check("sb_release", 32'(bus.id_unlock), 1);
        check("sb_pend0",   32'(bus.pend_cnt), 0);

        // Capacity
        for (int r = 1; r <= 4; r++) issue_gpr(5'(r));
        bus.iss_gpr = 1; bus.iss_addr = 5; #1;
        check("cap_pend4",  32'(bus.pend_cnt), 4);
        check("cap_ready",  32'(bus.iss_ready), 0);
        bus.iss_valid = 1; bus.cmp_valid = 1; bus.cmp_gpr = 1; bus.cmp_addr = 1; #1;
        check("cap_ready_cmp", 32'(bus.iss_ready), 0);
        tick();
        bus.iss_valid = 0; bus.cmp_valid = 0;
        check("cap_pend3",  32'(bus.pend_cnt), 3);
        bus.id_use = 2'b01; bus.id_addr[0] = 5; #1;
        check("cap_r5_free", 32'(bus.id_unlock), 1);
        bus.id_addr[0] = 2; #1;
        check("cap_r2_busy", 32'(bus.id_unlock), 0);

        // Flush with 3 pending; same-cycle issue/complete ignored
        bus.flush = 1;
        bus.iss_valid = 1; bus.iss_gpr = 1; bus.iss_addr = 6;
        bus.cmp_valid = 1; bus.cmp_gpr = 1; bus.cmp_addr = 3;
        tick();
        bus.flush = 0; bus.iss_valid = 0; bus.cmp_valid = 0;
        check("flush_pend",  32'(bus.pend_cnt), 0);
        check("flush_unlock", 32'(bus.id_unlock), 1);
        bus.id_addr[0] = 6; #1;
        check("flush_noiss", 32'(bus.id_unlock), 1);
        bus.id_use = 2'b00;

        // HI/LO
        bus.iss_valid = 1; bus.iss_gpr = 0; tick(); bus.iss_valid = 0;
        check("hl_pend1",   32'(bus.pend_cnt), 1);
        bus.id_use_lo = 1; #1;
        check("hl_stall",   32'(bus.id_unlock), 0);
        check("hl_wb_lo",   bus.hilo_latest, 32'h4c4c_4c4c);
        bus.stg_lo_we = 2'b10; bus.stg_lo[1] = 32'h1234;
        bus.cmp_valid = 1; bus.cmp_gpr = 0;
        tick();
        bus.cmp_valid = 0;
        check("hl_fwd",     bus.hilo_latest, 32'h1234);
        check("hl_unlock",  32'(bus.id_unlock), 1);
        check("hl_pend0",   32'(bus.pend_cnt), 0);
        bus.id_use_hi = 1; #1;
        check("hl_both",    bus.hilo_latest, 0);
        bus.id_use_lo = 0; bus.stg_hi_we = 2'b11;
        bus.stg_hi[0] = 32'hA0A0; bus.stg_hi[1] = 32'hB1B1; #1;
        check("hl_hi_young", bus.hilo_latest, 32'hA0A0);
        bus.id_use_hi = 0; bus.stg_hi_we = '0; bus.stg_lo_we = '0;

        // Reset together with flush, then stray completion
        for (int r = 10; r <= 12; r++) issue_gpr(5'(r));
        check("rf_pend3",   32'(bus.pend_cnt), 3);
        rst = 1; bus.flush = 1;
        tick();
        rst = 0; bus.flush = 0;
        check("rf_pend0",   32'(bus.pend_cnt), 0);
        bus.id_use = 2'b01; bus.id_addr[0] = 10; #1;
        check("rf_unlock",  32'(bus.id_unlock), 1);
        bus.cmp_valid = 1; bus.cmp_gpr = 1; bus.cmp_addr = 10;
        tick();
        bus.cmp_valid = 0;
        check("stray_pend", 32'(bus.pend_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
